// File: rtl/bcsa_pkg.sv
// rtl/bcsa_pkg.sv - shared types and constants for the bcsa error-recovery unit
//
// Purpose: FSM state type, default geometry and stats counter width used by
//          bcsa_err_recover and its block adder.
// Ports:   none (package).

package bcsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bcsa_state_t;

  localparam int BCSA_BLK    = 8;
  localparam int BCSA_WIDTH  = 32;
  localparam int BCSA_STAT_W = 16;

endpackage

// File: rtl/bcsa_blk_add.sv
// rtl/bcsa_blk_add.sv - combinational BLK-bit adder with carry-in and carry-out
//
// Purpose: one block of the exact ripple recomputation; time-multiplexed by
//          the top across all blocks.
// Ports:   a, b   in  BLK  block operands
//          cin    in  1    carry into the block
//          sum    out BLK  block sum
//          cout   out 1    carry out of the block

module bcsa_blk_add #(
  parameter int BLK = 8
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] sum,
  output logic           cout
);

  logic [BLK:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, cin};
  assign sum  = full[BLK-1:0];
  assign cout = full[BLK];

endmodule

// File: rtl/bcsa_err_recover.sv
// rtl/bcsa_err_recover.sv - sequential exact-sum recovery for block-carry-speculative adders
//
// Purpose: accepts a, b and the speculative adder's approx_sum, recomputes the
//          exact sum one BLK-bit block per cycle with a registered ripple carry,
//          and reports exact_sum, err_flag and a per-block mismatch mask.
// Ports:   clk, rst (async, active-high)
//          in_valid/in_ready, a, b, approx_sum       operand handshake
//          out_valid/out_ready, exact_sum, err_flag,
//          err_blocks                                result handshake
//          stat_clr, stat_ops, stat_errs             only with BCSA_ERR_STATS_EN
// Macro:   BCSA_ERR_STATS_EN adds saturating operation/error counters.

module bcsa_err_recover
  import bcsa_pkg::*;
#(
  parameter  int WIDTH = BCSA_WIDTH,
  parameter  int BLK   = BCSA_BLK,
  localparam int NBLK  = WIDTH / BLK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   approx_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   exact_sum,
  output logic             err_flag,
  output logic [NBLK-1:0]  err_blocks
`ifdef BCSA_ERR_STATS_EN
  ,
  input  logic                   stat_clr,
  output logic [BCSA_STAT_W-1:0] stat_ops,
  output logic [BCSA_STAT_W-1:0] stat_errs
`endif
);

  generate
    if ((WIDTH % BLK) != 0 || WIDTH < BLK) begin : g_bad_geometry
      $error("bcsa_err_recover: WIDTH must be a nonzero multiple of BLK");
    end
  endgenerate

  localparam int KW = (NBLK > 1) ? $clog2(NBLK) : 1;

  bcsa_state_t      state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH:0]   approx_r;
  logic [KW-1:0]    k;
  logic             carry;

  int               base;
  logic [BLK-1:0]   blk_sum;
  logic             blk_cout;
  logic             blk_mis;
  logic             cout_mis;
  logic             last_blk;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign base     = int'(k) * BLK;
  assign last_blk = (k == KW'(NBLK - 1));

  bcsa_blk_add #(.BLK(BLK)) u_blk_add (
    .a    (a_r[base +: BLK]),
    .b    (b_r[base +: BLK]),
    .cin  (carry),
    .sum  (blk_sum),
    .cout (blk_cout)
  );

  assign blk_mis  = (blk_sum != approx_r[base +: BLK]);
  // The carry-out bit of the whole sum is folded into the top block's flag.
  assign cout_mis = (blk_cout != approx_r[WIDTH]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      a_r        <= '0;
      b_r        <= '0;
      approx_r   <= '0;
      k          <= '0;
      carry      <= 1'b0;
      exact_sum  <= '0;
      err_blocks <= '0;
      err_flag   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r        <= a;
            b_r        <= b;
            approx_r   <= approx_sum;
            k          <= '0;
            carry      <= 1'b0;
            exact_sum  <= '0;
            err_blocks <= '0;
            err_flag   <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          exact_sum[base +: BLK] <= blk_sum;
          carry                  <= blk_cout;
          err_blocks[k]          <= blk_mis;
          k                      <= k + 1'b1;
          if (last_blk) begin
            exact_sum[WIDTH]       <= blk_cout;
            err_blocks[NBLK-1]     <= blk_mis | cout_mis;
            // Lower mask bits are already final; the top bit is still clear here.
            err_flag               <= (|err_blocks) | blk_mis | cout_mis;
            state                  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BCSA_ERR_STATS_EN
  logic handshake;
  assign handshake = (state == DONE) && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops  <= '0;
      stat_errs <= '0;
    end else if (stat_clr) begin
      stat_ops  <= '0;
      stat_errs <= '0;
    end else if (handshake) begin
      if (stat_ops != '1) stat_ops <= stat_ops + 1'b1;
      if (err_flag && stat_errs != '1) stat_errs <= stat_errs + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bcsa_err_recover.sv
// tb/tb_bcsa_err_recover.sv - directed self-checking bench for bcsa_err_recover

module tb_bcsa_err_recover;

  localparam int WIDTH = 32;
  localparam int NBLK  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  a = '0;
  logic [WIDTH-1:0]  b = '0;
  logic [WIDTH:0]    approx_sum = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WIDTH:0]    exact_sum;
  logic              err_flag;
  logic [NBLK-1:0]   err_blocks;
`ifdef BCSA_ERR_STATS_EN
  logic              stat_clr = 1'b0;
  logic [15:0]       stat_ops;
  logic [15:0]       stat_errs;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bcsa_err_recover dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .approx_sum (approx_sum),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .exact_sum  (exact_sum),
    .err_flag   (err_flag),
    .err_blocks (err_blocks)
`ifdef BCSA_ERR_STATS_EN
    ,
    .stat_clr   (stat_clr),
    .stat_ops   (stat_ops),
    .stat_errs  (stat_errs)
`endif
  );

  // Presents one operand set, waits for out_valid; lat is cycles from the
  // accept edge to out_valid, or -1 on timeout.
  task automatic start_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic [WIDTH:0] tap, output int lat);
    @(negedge clk);
    a = ta; b = tb; approx_sum = tap; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = '0; b = '0; approx_sum = '0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  // One-cycle out_ready pulse; returns in_ready seen just after the edge.
  task automatic release_op(output logic rdy_after);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    rdy_after = in_ready;
  endtask

  task automatic test_reset;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL reset_hs: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
      miscompares++;
    end
    vectors++;
    if (exact_sum !== 33'h0 || err_flag !== 1'b0 || err_blocks !== 4'b0000) begin
      $display("FAIL reset_data: sum=%h flag=%b blocks=%b expected 0/0/0000",
               exact_sum, err_flag, err_blocks);
      miscompares++;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_exact;
    int lat;
    logic r;
    start_op(32'h12345678, 32'h11111111, 33'h023456789, lat);
    vectors++;
    if (lat !== 4) begin
      $display("FAIL exact_latency: got %0d expected 4", lat);
      miscompares++;
    end
    vectors++;
    if (exact_sum !== 33'h023456789 || err_flag !== 1'b0 || err_blocks !== 4'b0000) begin
      $display("FAIL exact_result: sum=%h flag=%b blocks=%b expected 023456789/0/0000",
               exact_sum, err_flag, err_blocks);
      miscompares++;
    end
    release_op(r);
    vectors++;
    if (r !== 1'b1) begin
      $display("FAIL exact_release: in_ready=%b expected 1", r);
      miscompares++;
    end
  endtask

  task automatic test_lost_carry;
    int lat;
    logic r;
    start_op(32'h000000FF, 32'h00000001, 33'h000000000, lat);
    vectors++;
    if (lat !== 4 || exact_sum !== 33'h000000100 || err_flag !== 1'b1 || err_blocks !== 4'b0010) begin
      $display("FAIL lost_carry: lat=%0d sum=%h flag=%b blocks=%b expected 4/000000100/1/0010",
               lat, exact_sum, err_flag, err_blocks);
      miscompares++;
    end
    release_op(r);
  endtask

  task automatic test_full_chain;
    int lat;
    logic r;
    start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 33'h1FFFFFFFE, lat);
    vectors++;
    if (lat !== 4 || exact_sum !== 33'h1FFFFFFFE || err_flag !== 1'b0 || err_blocks !== 4'b0000) begin
      $display("FAIL full_chain_ok: lat=%0d sum=%h flag=%b blocks=%b expected 4/1FFFFFFFE/0/0000",
               lat, exact_sum, err_flag, err_blocks);
      miscompares++;
    end
    release_op(r);
    start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 33'h0FFFFFFFE, lat);
    vectors++;
    if (lat !== 4 || exact_sum !== 33'h1FFFFFFFE || err_flag !== 1'b1 || err_blocks !== 4'b1000) begin
      $display("FAIL full_chain_cout: lat=%0d sum=%h flag=%b blocks=%b expected 4/1FFFFFFFE/1/1000",
               lat, exact_sum, err_flag, err_blocks);
      miscompares++;
    end
    release_op(r);
  endtask

  task automatic test_backpressure;
    int lat;
    logic r;
    start_op(32'h000000FF, 32'h00000001, 33'h000000000, lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 32'hA5A5A5A5 + c; b = 32'h5A5A5A5A; approx_sum = 33'h0;
      @(posedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || exact_sum !== 33'h000000100 ||
          err_flag !== 1'b1 || err_blocks !== 4'b0010) begin
        $display("FAIL backpressure_hold%0d: ov=%b ir=%b sum=%h flag=%b blocks=%b expected 1/0/000000100/1/0010",
                 c, out_valid, in_ready, exact_sum, err_flag, err_blocks);
        miscompares++;
      end
    end
    in_valid = 1'b0;
    release_op(r);
    vectors++;
    if (r !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b expected 1/0", r, out_valid);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid_run;
    int lat;
    logic r;
    logic seen_valid;
    @(negedge clk);
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; approx_sum = 33'h0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (exact_sum !== 33'h0 || err_flag !== 1'b0 || err_blocks !== 4'b0000 ||
        out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL midrun_reset: sum=%h flag=%b blocks=%b ov=%b ir=%b expected 0/0/0000/0/1",
               exact_sum, err_flag, err_blocks, out_valid, in_ready);
      miscompares++;
    end
    seen_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      seen_valid |= out_valid;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      seen_valid |= out_valid;
    end
    vectors++;
    if (seen_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL midrun_no_output: out_valid_seen=%b in_ready=%b expected 0/1", seen_valid, in_ready);
      miscompares++;
    end
    start_op(32'h12345678, 32'h11111111, 33'h023456789, lat);
    vectors++;
    if (lat !== 4 || exact_sum !== 33'h023456789 || err_flag !== 1'b0 || err_blocks !== 4'b0000) begin
      $display("FAIL midrun_fresh: lat=%0d sum=%h flag=%b blocks=%b expected 4/023456789/0/0000",
               lat, exact_sum, err_flag, err_blocks);
      miscompares++;
    end
    release_op(r);
  endtask

`ifdef BCSA_ERR_STATS_EN
  task automatic test_stats;
    int lat;
    logic r;
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    start_op(32'h12345678, 32'h11111111, 33'h023456789, lat);
    release_op(r);
    start_op(32'h000000FF, 32'h00000001, 33'h000000000, lat);
    release_op(r);
    start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 33'h1FFFFFFFE, lat);
    release_op(r);
    vectors++;
    if (stat_ops !== 16'd3 || stat_errs !== 16'd1) begin
      $display("FAIL stats_count: ops=%0d errs=%0d expected 3/1", stat_ops, stat_errs);
      miscompares++;
    end
    start_op(32'h000000FF, 32'h00000001, 33'h000000000, lat);
    @(negedge clk);
    out_ready = 1'b1;
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    stat_clr = 1'b0;
    vectors++;
    if (stat_ops !== 16'd0 || stat_errs !== 16'd0 || in_ready !== 1'b1) begin
      $display("FAIL stats_clr_wins: ops=%0d errs=%0d ir=%b expected 0/0/1", stat_ops, stat_errs, in_ready);
      miscompares++;
    end
  endtask
`endif

  initial begin
    test_reset;
    test_exact;
    test_lost_carry;
    test_full_chain;
    test_backpressure;
    test_reset_mid_run;
`ifdef BCSA_ERR_STATS_EN
    test_stats;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
